// File: rtl/siggen_multi.sv
// Multi-channel programmable pulse-train generator. Each channel runs
// independently in continuous, burst or one-shot mode with double-buffered config.
module siggen_multi #(
    parameter int NCH     = 2,
    parameter int CNT_W   = 24,
    parameter int BURST_W = 8
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic [NCH-1:0]     trig,
    output logic [NCH-1:0]     sigout,
    output logic [NCH-1:0]     period_tick,
    output logic [NCH-1:0]     busy
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_CONT    = 2'b01,
        MODE_BURST   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        mode_t              mode;
        logic [CNT_W-1:0]   period;
        logic [CNT_W-1:0]   high;
        logic [BURST_W-1:0] burst;
    } cfg_t;

    function automatic logic burst_like(input mode_t m);
        return (m == MODE_BURST) || (m == MODE_ONESHOT);
    endfunction

    // One-shot behaves as a burst of exactly one period.
    function automatic logic [BURST_W-1:0] burst_len(input cfg_t c);
        return (c.mode == MODE_ONESHOT) ? BURST_W'(1) : c.burst;
    endfunction

    cfg_t cfg_bus;
    assign cfg_bus = '{mode: mode_t'(cfg_mode), period: cfg_period,
                       high: cfg_high, burst: cfg_burst};

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        state_t             state_q, state_d;
        cfg_t               act_q, act_d, shd_q, shd_d;
        cfg_t               eff, nxt;
        logic               pend_q, pend_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
        logic [BURST_W-1:0] rem_q, rem_d;
        logic               sig_q, sig_d, tick_q, tick_d;
        logic               we, wrap, realign, last, stop;

        assign we      = cfg_we && (cfg_ch == 3'(ch));
        assign cnt_inc = cnt_q + CNT_W'(1);

        always_comb begin
            // NOTE: every variable gets a default before any branch, so no path
            // leaves one unassigned and no latch is inferred.
            state_d = state_q;
            act_d   = act_q;
            shd_d   = shd_q;
            pend_d  = pend_q;
            cnt_d   = cnt_q;
            rem_d   = rem_q;
            sig_d   = sig_q;
            tick_d  = 1'b0;
            stop    = 1'b0;
            // An idle channel sees a same-cycle write before it evaluates trig.
            eff     = we ? cfg_bus : act_q;
            nxt     = pend_q ? shd_q : act_q;
            wrap    = (cnt_q == act_q.period - CNT_W'(1));
            realign = trig[ch] && (act_q.mode == MODE_CONT);
            last    = burst_like(act_q.mode) && (rem_q == BURST_W'(1));

            if (state_q == ST_IDLE) begin
                act_d = eff;
                if ((!we && act_q.mode == MODE_CONT && act_q.period != '0) ||
                    (trig[ch] && burst_like(eff.mode) && eff.period != '0 &&
                     burst_len(eff) != '0)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    sig_d   = (eff.high != '0);
                    tick_d  = 1'b1;
                    rem_d   = burst_len(eff);
                end
            end else begin
                if (wrap || realign) begin
                    // Period boundary: pending shadow becomes active for the next period.
                    act_d  = nxt;
                    pend_d = 1'b0;
                    stop   = last || (nxt.mode == MODE_OFF) || (nxt.period == '0) ||
                             (burst_like(nxt.mode) && !burst_like(act_q.mode) &&
                              burst_len(nxt) == '0);
                    if (stop) begin
                        state_d = ST_IDLE;
                        sig_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d  = '0;
                        sig_d  = (nxt.high != '0);
                        tick_d = 1'b1;
                        rem_d  = burst_like(act_q.mode) ? rem_q - BURST_W'(1)
                                                        : burst_len(nxt);
                    end
                end else begin
                    cnt_d = cnt_inc;
                    sig_d = (cnt_inc < act_q.high);
                end
                if (we) begin
                    if (stop) begin
                        act_d = cfg_bus;
                    end else begin
                        shd_d  = cfg_bus;
                        pend_d = 1'b1;
                    end
                end
            end
        end

        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of evaluation order.
        always_ff @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                act_q   <= '0;
                shd_q   <= '0;
                pend_q  <= 1'b0;
                cnt_q   <= '0;
                rem_q   <= '0;
                sig_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                act_q   <= act_d;
                shd_q   <= shd_d;
                pend_q  <= pend_d;
                cnt_q   <= cnt_d;
                rem_q   <= rem_d;
                sig_q   <= sig_d;
                tick_q  <= tick_d;
            end
        end

        assign sigout[ch]      = sig_q;
        assign period_tick[ch] = tick_q;
        assign busy[ch]        = (state_q == ST_RUN);
    end

endmodule

// File: doc/siggen_multi.md
# siggen_multi

Multi-channel programmable test-signal generator for the frequency-measurement experiments. Each of NCH channels produces a registered pulse train with a runtime-programmable period and high time, in continuous, burst or one-shot mode, clocked from the 50 MHz system clock. Configuration is double-buffered, so period and duty changes take effect only at period boundaries and never produce a runt pulse. It drives the counter/meter blocks as the stimulus source.

## Interface
- NCH, 2: number of independent channels (1..8)
- CNT_W, 24: period/high-time counter width (max period 2^CNT_W-1 sysclk cycles)
- BURST_W, 8: burst length counter width
- sysclk  in  1  system clock, 50 MHz, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  write strobe, one cycle, for channel cfg_ch
- cfg_ch  in  3  target channel; values >= NCH are ignored
- cfg_mode  in  2  00 OFF, 01 CONT, 10 BURST, 11 ONESHOT
- cfg_period  in  CNT_W  period P in sysclk cycles
- cfg_high  in  CNT_W  high time H in sysclk cycles
- cfg_burst  in  BURST_W  burst length B in periods (BURST mode only)
- trig  in  NCH  per-channel start/realign strobe, one cycle
- sigout  out  NCH  generated signal, registered
- period_tick  out  NCH  one-cycle pulse on the cycle each period starts
- busy  out  NCH  channel running

## Operation
- Per channel: active regs (mode, P, H, B), shadow regs, pending flag, cnt (CNT_W), rem (BURST_W), running flag.
- Reset: all regs 0, mode OFF, sigout=0, period_tick=0, busy=0, pending=0.
- Config write, idle channel (busy=0): the active regs load at the cfg_we edge. Running channel: the shadow regs load and pending is set. A second write before application overwrites the shadow (last write wins).
- A period start is an edge where cnt<=0, sigout<=(H>0), period_tick<=1, busy<=1. On every other running edge, cnt<=cnt+1 and sigout<=(cnt+1<H). The wrap edge is the edge where cnt==P-1, and it is a period start unless the channel stops.
- At the wrap edge with pending=1, the shadow is copied to active and pending is cleared. The new period uses the new P/H. If the new mode is OFF or the new P is 0, the channel stops.
- Stop: running<=0, busy<=0, sigout<=0, cnt<=0, no period_tick.
- H>=P: sigout stays high for the whole run. H=0: sigout stays low, but ticks still fire.
- P=0: the channel never runs, in any mode.
- CONT: when idle with mode CONT and P>0, the channel starts a period on the next edge. A trig while running forces a period start, realigning the phase, and applies any pending shadow.
- BURST: trig while idle and B>0 starts a period and loads rem<=B. Each wrap decrements rem; a wrap with rem==1 stops the channel. The result is exactly B*P busy cycles and B high pulses. Trig while busy is ignored. B=0 means trig is ignored.
- ONESHOT: identical to BURST with B forced to 1.
- OFF: trig is ignored, and sigout/busy are held 0.
- cfg_we and trig in the same cycle on an idle channel: the config applies first, and trig uses the new values.
- Channels are fully independent; no shared state except the cfg bus.

## Timing
- Trig sampled at edge t: sigout (if H>0), period_tick and busy are high from edge t+1.
- CONT written at edge t to an idle channel: the first period starts at edge t+1.
- Output period is P cycles, with sigout high H cycles per period. With sysclk at 50 MHz, f = 50e6/P.
- All outputs are registered, with no combinational path from inputs to outputs.
- Asserting rst_n low mid-run clears outputs immediately (asynchronously). After release, the channel is in OFF and does not resume.

## Test plan
- Reset release, then ch0 write CONT, P=16000, H=8000: sigout0 is 3125 Hz at 50% duty, period_tick0 every 16000 cycles, and first high at the edge after the write.
- ch1 BURST, P=10, H=3, B=4, single trig: busy1 high exactly 40 cycles, 4 pulses of 3 cycles each, 4 ticks. A trig during the burst is ignored.
- ch0 running CONT P=8000/H=4000, write P=4000/H=1000 mid-period: the current 8000-cycle period completes unchanged, then 4000/1000 periods follow with no runt.
- Edge values: H=0 gives sigout stuck 0 with ticks present; H=P gives sigout stuck 1; P=0 gives busy never set; B=0 trig gives no activity; cfg_ch=7 with NCH=2 gives no channel change.
- ONESHOT P=5, H=2, with trig and cfg_we (H=4) in the same cycle: exactly one 4-cycle pulse in a 5-cycle busy window.
- rst_n asserted mid-burst: all outputs 0 immediately. After release with no writes, no output activity.
